// File: rtl/decode_stage_q_pkg.sv
// Shared decode definitions: ALU function codes, branch-condition bit order,
// opcode/funct encodings and the decoded uop bundle.
package decode_stage_q_pkg;

   // ALU function codes
   localparam logic [3:0] ALUFN_ADD  = 4'd0;
   localparam logic [3:0] ALUFN_SUB  = 4'd1;
   localparam logic [3:0] ALUFN_AND  = 4'd2;
   localparam logic [3:0] ALUFN_OR   = 4'd3;
   localparam logic [3:0] ALUFN_XOR  = 4'd4;
   localparam logic [3:0] ALUFN_NOR  = 4'd5;
   localparam logic [3:0] ALUFN_SLL  = 4'd6;
   localparam logic [3:0] ALUFN_SRL  = 4'd7;
   localparam logic [3:0] ALUFN_SRA  = 4'd8;
   localparam logic [3:0] ALUFN_ROTR = 4'd9;

   // BCond bit positions: {lt,eq,gt,lz,ez,gz}
   localparam int unsigned BC_LT = 5;
   localparam int unsigned BC_EQ = 4;
   localparam int unsigned BC_GT = 3;
   localparam int unsigned BC_LZ = 2;
   localparam int unsigned BC_EZ = 1;
   localparam int unsigned BC_GZ = 0;

   localparam logic [5:0] BCOND_BEQ  = 6'b010000;
   localparam logic [5:0] BCOND_BNE  = 6'b101000;
   localparam logic [5:0] BCOND_BLEZ = 6'b000110;
   localparam logic [5:0] BCOND_BGTZ = 6'b000001;
   localparam logic [5:0] BCOND_BLTZ = 6'b000100;
   localparam logic [5:0] BCOND_BGEZ = 6'b000011;

   // Opcodes
   localparam logic [5:0] OP_RTYPE  = 6'h00;
   localparam logic [5:0] OP_REGIMM = 6'h01;
   localparam logic [5:0] OP_BEQ    = 6'h04;
   localparam logic [5:0] OP_BNE    = 6'h05;
   localparam logic [5:0] OP_BLEZ   = 6'h06;
   localparam logic [5:0] OP_BGTZ   = 6'h07;
   localparam logic [5:0] OP_ADDI   = 6'h08;
   localparam logic [5:0] OP_ADDIU  = 6'h09;
   localparam logic [5:0] OP_ANDI   = 6'h0C;
   localparam logic [5:0] OP_ORI    = 6'h0D;
   localparam logic [5:0] OP_XORI   = 6'h0E;
   localparam logic [5:0] OP_LUI    = 6'h0F;
   localparam logic [5:0] OP_LB     = 6'h20;
   localparam logic [5:0] OP_LH     = 6'h21;
   localparam logic [5:0] OP_LWL    = 6'h22;
   localparam logic [5:0] OP_LW     = 6'h23;
   localparam logic [5:0] OP_LBU    = 6'h24;
   localparam logic [5:0] OP_LHU    = 6'h25;
   localparam logic [5:0] OP_SB     = 6'h28;
   localparam logic [5:0] OP_SH     = 6'h29;
   localparam logic [5:0] OP_SW     = 6'h2B;

   // R-type funct codes
   localparam logic [5:0] F_SLL  = 6'd0;
   localparam logic [5:0] F_SRL  = 6'd2;
   localparam logic [5:0] F_SRA  = 6'd3;
   localparam logic [5:0] F_SLLV = 6'd4;
   localparam logic [5:0] F_SRLV = 6'd6;
   localparam logic [5:0] F_SRAV = 6'd7;
   localparam logic [5:0] F_ADD  = 6'd32;
   localparam logic [5:0] F_ADDU = 6'd33;
   localparam logic [5:0] F_SUB  = 6'd34;
   localparam logic [5:0] F_SUBU = 6'd35;
   localparam logic [5:0] F_AND  = 6'd36;
   localparam logic [5:0] F_OR   = 6'd37;
   localparam logic [5:0] F_XOR  = 6'd38;
   localparam logic [5:0] F_NOR  = 6'd39;

   typedef struct packed {
      logic [4:0]  rs;
      logic [4:0]  rt;
      logic [4:0]  wreg;
      logic [3:0]  alufn;
      logic        regwr;
      logic        regwsrc;
      logic        alusrc1;
      logic        alusrc2;
      logic        memwr;
      logic [4:0]  shamt;
      logic [5:0]  bcond;
      logic [31:0] imm32;
      logic        illegal;
   } uop_t;

   localparam int unsigned UOP_W = $bits(uop_t);

   // Logical immediates (ANDI/ORI/XORI/LUI) zero-extend; everything else sign-extends.
   function automatic logic [31:0] ext_imm(input logic [5:0] op, input logic [15:0] imm);
      if (op[5:2] == 4'b0011) begin
         return {16'h0000, imm};
      end
      return {{16{imm[15]}}, imm};
   endfunction

endpackage

// File: rtl/idec_core.sv
// Combinational MIPS instruction decoder: 32-bit instruction word to uop bundle.
module idec_core
   import decode_stage_q_pkg::*;
#(
   parameter bit EN_ROTR = 1'b1
) (
   input  logic [31:0] instr,
   output uop_t        uop
);

   logic [5:0] opcode;
   logic [5:0] funct;
   logic [4:0] rt;
   logic       legal;

   assign opcode = instr[31:26];
   assign funct  = instr[5:0];
   assign rt     = instr[20:16];

   // Decode opcode/funct into control fields; unsupported encodings are squashed at the end.
   always_comb begin
      uop         = '0;
      legal       = 1'b1;
      uop.rs      = instr[25:21];
      uop.rt      = rt;
      uop.wreg    = (opcode == OP_RTYPE) ? instr[15:11] : rt;
      uop.shamt   = instr[10:6];
      uop.imm32   = ext_imm(opcode, instr[15:0]);

      case (opcode)
         OP_RTYPE: begin
            uop.regwr   = 1'b1;
            uop.alusrc1 = (funct[5:3] == 3'b000);
            case (funct)
               F_SLL, F_SLLV: uop.alufn = ALUFN_SLL;
               F_SRL, F_SRLV: uop.alufn = (EN_ROTR && instr[21]) ? ALUFN_ROTR : ALUFN_SRL;
               F_SRA, F_SRAV: uop.alufn = ALUFN_SRA;
               F_ADD, F_ADDU: uop.alufn = ALUFN_ADD;
               F_SUB, F_SUBU: uop.alufn = ALUFN_SUB;
               F_AND:         uop.alufn = ALUFN_AND;
               F_OR:          uop.alufn = ALUFN_OR;
               F_XOR:         uop.alufn = ALUFN_XOR;
               F_NOR:         uop.alufn = ALUFN_NOR;
               default:       legal     = 1'b0;
            endcase
         end
         OP_REGIMM: begin
            case (rt)
               5'd0, 5'd2, 5'd16, 5'd18: uop.bcond = BCOND_BLTZ;
               5'd1, 5'd3, 5'd17, 5'd19: uop.bcond = BCOND_BGEZ;
               default:                  legal     = 1'b0;
            endcase
         end
         OP_BEQ:  uop.bcond = BCOND_BEQ;
         OP_BNE:  uop.bcond = BCOND_BNE;
         OP_BLEZ: uop.bcond = BCOND_BLEZ;
         OP_BGTZ: uop.bcond = BCOND_BGTZ;
         OP_ADDI, OP_ADDIU, OP_ANDI, OP_ORI, OP_XORI, OP_LUI: begin
            uop.alusrc2 = 1'b1;
            uop.regwr   = 1'b1;
            case (opcode)
               OP_ANDI: uop.alufn = ALUFN_AND;
               OP_ORI:  uop.alufn = ALUFN_OR;
               OP_XORI: uop.alufn = ALUFN_XOR;
               OP_LUI: begin
                  uop.alufn   = ALUFN_SLL;
                  uop.alusrc1 = 1'b1;
                  uop.shamt   = 5'd16;
               end
               default: uop.alufn = ALUFN_ADD;
            endcase
         end
         OP_LB, OP_LH, OP_LWL, OP_LW, OP_LBU, OP_LHU: begin
            uop.regwsrc = 1'b1;
            uop.regwr   = 1'b1;
            uop.alusrc2 = 1'b1;
            uop.alufn   = ALUFN_ADD;
         end
         OP_SB, OP_SH, OP_SW: begin
            uop.memwr   = 1'b1;
            uop.alusrc2 = 1'b1;
            uop.alufn   = ALUFN_ADD;
         end
         default: legal = 1'b0;
      endcase

      // Illegal uops still flow down the pipe but must have no architectural side effects.
      if (!legal) begin
         uop.illegal = 1'b1;
         uop.regwr   = 1'b0;
         uop.memwr   = 1'b0;
         uop.bcond   = '0;
         uop.alufn   = '0;
      end
   end

endmodule

// File: rtl/decode_stage_q.sv
// Registered decode stage: decodes on push and holds up to DEPTH uops for execute.
module decode_stage_q
   import decode_stage_q_pkg::*;
#(
   parameter int unsigned DEPTH   = 2,
   parameter int unsigned PC_W    = 32,
   parameter bit          EN_ROTR = 1'b1,
   parameter int unsigned CNT_W   = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             flush,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [31:0]      in_instr,
   input  logic [PC_W-1:0]  in_pc,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [PC_W-1:0]  out_pc,
   output logic [4:0]       out_rs,
   output logic [4:0]       out_rt,
   output logic [4:0]       out_wreg,
   output logic [3:0]       out_alufn,
   output logic             out_regwr,
   output logic             out_regwsrc,
   output logic             out_alusrc1,
   output logic             out_alusrc2,
   output logic             out_memwr,
   output logic [4:0]       out_shamt,
   output logic [5:0]       out_bcond,
   output logic [31:0]      out_imm32,
   output logic             out_illegal,
   output logic [CNT_W-1:0] illegal_cnt
);

   localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int unsigned CW    = $clog2(DEPTH + 1);

   logic [UOP_W-1:0] uop_mem_q [DEPTH];
   logic [PC_W-1:0]  pc_mem_q  [DEPTH];
   logic [PTR_W-1:0] wptr_q, wptr_d;
   logic [PTR_W-1:0] rptr_q, rptr_d;
   logic [CW-1:0]    count_q, count_d;
   logic [CNT_W-1:0] illegal_cnt_q, illegal_cnt_d;

   uop_t dec_uop;
   uop_t head_uop;
   logic full;
   logic push;
   logic pop;

   idec_core #(
      .EN_ROTR (EN_ROTR)
   ) u_idec_core (
      .instr (in_instr),
      .uop   (dec_uop)
   );

   assign full      = (count_q == CW'(DEPTH));
   assign out_valid = (count_q != '0);
   assign in_ready  = rst_n & ~full;
   assign push      = in_valid & in_ready & ~flush;
   assign pop       = out_valid & out_ready & ~flush;

   assign head_uop    = uop_t'(uop_mem_q[rptr_q]);
   assign out_pc      = pc_mem_q[rptr_q];
   assign out_rs      = head_uop.rs;
   assign out_rt      = head_uop.rt;
   assign out_wreg    = head_uop.wreg;
   assign out_alufn   = head_uop.alufn;
   assign out_regwr   = head_uop.regwr;
   assign out_regwsrc = head_uop.regwsrc;
   assign out_alusrc1 = head_uop.alusrc1;
   assign out_alusrc2 = head_uop.alusrc2;
   assign out_memwr   = head_uop.memwr;
   assign out_shamt   = head_uop.shamt;
   assign out_bcond   = head_uop.bcond;
   assign out_imm32   = head_uop.imm32;
   assign out_illegal = head_uop.illegal;
   assign illegal_cnt = illegal_cnt_q;

   // Next pointers and occupancy; flush empties the queue and drops any push.
   always_comb begin
      wptr_d  = wptr_q;
      rptr_d  = rptr_q;
      count_d = count_q;
      if (flush) begin
         wptr_d  = '0;
         rptr_d  = '0;
         count_d = '0;
      end else begin
         if (push) begin
            wptr_d = wptr_q + PTR_W'(1);
         end
         if (pop) begin
            rptr_d = rptr_q + PTR_W'(1);
         end
         case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
         endcase
      end
   end

   // Saturating count of illegal uops consumed by execute.
   always_comb begin
      illegal_cnt_d = illegal_cnt_q;
      if (pop && head_uop.illegal && (illegal_cnt_q != '1)) begin
         illegal_cnt_d = illegal_cnt_q + CNT_W'(1);
      end
   end

   // Queue control state register.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         wptr_q        <= '0;
         rptr_q        <= '0;
         count_q       <= '0;
         illegal_cnt_q <= '0;
      end else begin
         wptr_q        <= wptr_d;
         rptr_q        <= rptr_d;
         count_q       <= count_d;
         illegal_cnt_q <= illegal_cnt_d;
      end
   end

   // Uop and PC storage, written at the tail on push.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) begin
            uop_mem_q[i] <= '0;
            pc_mem_q[i]  <= '0;
         end
      end else if (push) begin
         uop_mem_q[wptr_q] <= UOP_W'(dec_uop);
         pc_mem_q[wptr_q]  <= in_pc;
      end
   end

endmodule
